// File: rtl/bht_sweep_predictor.sv
// Branch history table: 2-bit counters with valid bits, cleared by a one-entry-per-cycle sweep.
// Optional macro BHT_WRITE_BYPASS_EN forwards a same-index update into the same-cycle lookup.
module bht_sweep_predictor #(
  parameter int NR_ENTRIES = 128,
  parameter int VLEN       = 32,
  parameter int PC_OFFSET  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  output logic            init_done_o
);

  localparam int IDX = $clog2(NR_ENTRIES);
  localparam logic [IDX-1:0] LAST_IDX = IDX'(NR_ENTRIES - 1);

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDX-1:0] r_sweep_idx, w_sweep_idx_nxt;

  logic           r_valid [NR_ENTRIES];
  logic [1:0]     r_ctr   [NR_ENTRIES];

  logic           r_pred_vld_p1;
  logic           r_pred_taken_p1;

  logic [IDX-1:0] w_lk_idx, w_upd_idx, w_widx;
  logic [2:0]     w_rd_entry, w_upd_entry, w_lk_entry, w_wdata;
  logic           w_lk_fire, w_upd_en, w_we;
  logic           w_unused_pc;

  function automatic logic [2:0] train_entry(input logic valid, input logic [1:0] ctr,
                                             input logic taken);
    logic [2:0] res;
    if (!valid)
      res = {1'b1, taken ? 2'b10 : 2'b01};
    else if (taken)
      res = {1'b1, (ctr == 2'b11) ? 2'b11 : ctr + 2'b01};
    else
      res = {1'b1, (ctr == 2'b00) ? 2'b00 : ctr - 2'b01};
    return res;
  endfunction

  // Untagged table: only the index bits of each PC are meaningful.
  assign w_lk_idx    = lookup_pc_i[PC_OFFSET +: IDX];
  assign w_upd_idx   = update_pc_i[PC_OFFSET +: IDX];
  assign w_unused_pc = ^{lookup_pc_i, update_pc_i};

  assign w_lk_fire   = lookup_valid_i && (r_state == ST_IDLE);
  assign w_upd_en    = update_valid_i && (r_state == ST_IDLE) && !flush_i;

  assign w_rd_entry  = {r_valid[w_lk_idx], r_ctr[w_lk_idx]};
  assign w_upd_entry = train_entry(r_valid[w_upd_idx], r_ctr[w_upd_idx], update_taken_i);

`ifdef BHT_WRITE_BYPASS_EN
  assign w_lk_entry = (w_upd_en && (w_upd_idx == w_lk_idx)) ? w_upd_entry : w_rd_entry;
`else
  assign w_lk_entry = w_rd_entry;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      ST_SWEEP: begin
        if (flush_i) begin
          w_sweep_idx_nxt = '0;
        end else begin
          w_sweep_idx_nxt = r_sweep_idx + IDX'(1);
          if (r_sweep_idx == LAST_IDX) w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_i) begin
          w_state_nxt     = ST_SWEEP;
          w_sweep_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = ST_SWEEP;
        w_sweep_idx_nxt = '0;
      end
    endcase
  end

  // Single write port: the sweep owns it in SWEEP, training owns it in IDLE.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_upd_idx;
    w_wdata = w_upd_entry;
    if (r_state == ST_SWEEP) begin
      w_we    = 1'b1;
      w_widx  = r_sweep_idx;
      w_wdata = 3'b001;
    end else if (w_upd_en) begin
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_we) begin
      r_valid[w_widx] <= w_wdata[2];
      r_ctr[w_widx]   <= w_wdata[1:0];
    end
  end

  // Stage p1: registered prediction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pred_vld_p1   <= 1'b0;
      r_pred_taken_p1 <= 1'b0;
    end else begin
      r_pred_vld_p1   <= w_lk_fire;
      r_pred_taken_p1 <= w_lk_fire & w_lk_entry[2] & w_lk_entry[1];
    end
  end

  assign pred_valid_o = r_pred_vld_p1;
  assign pred_taken_o = r_pred_taken_p1;
  assign init_done_o  = (r_state == ST_IDLE);

endmodule

// File: doc/bht_sweep_predictor.md
Name: bht_sweep_predictor

Overview:
- Branch history table for the 32-bit compressed-capable core; sits in the frontend directly upstream of the fetch-side branch decision logic.
- Provides a 1-cycle registered taken/not-taken prediction per looked-up PC and trains 2-bit saturating counters from resolved branches.
- On reset or flush, clears its storage through a one-entry-per-cycle sweep, so it maps to single-port-write SRAM.

Parameters:
- NR_ENTRIES, 128, number of table entries; power of two, >= 4.
- VLEN, 32, virtual PC width.
- PC_OFFSET, 1, low PC bits dropped before indexing (1 because of compressed instructions).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  start a table clear sweep.
- lookup_valid_i  input  1  lookup request this cycle.
- lookup_pc_i  input  VLEN  PC to predict.
- pred_valid_o  output  1  prediction available (one cycle after lookup).
- pred_taken_o  output  1  predicted direction.
- update_valid_i  input  1  resolved-branch training request.
- update_pc_i  input  VLEN  PC of the resolved branch.
- update_taken_i  input  1  resolved direction.
- init_done_o  output  1  high when the table is usable (IDLE state).

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Index: IDX = log2(NR_ENTRIES) bits, taken from pc[PC_OFFSET+IDX-1 : PC_OFFSET]; upper PC bits are ignored (no tag).
- Entry contents: valid bit plus 2-bit counter. Cleared entry: valid=0, ctr=2'b01.
- States:
  - SWEEP: clear the entry at sweep_idx, then increment sweep_idx. After clearing entry NR_ENTRIES-1, go to IDLE.
  - IDLE: normal operation.
- Reset, rst_i high at a clock edge:
  - state=SWEEP, sweep_idx=0, pred_valid_o=0, pred_taken_o=0, init_done_o=0.
  - Reset mid-sweep restarts the sweep at 0.
- Sweep length: exactly NR_ENTRIES cycles after rst_i deasserts. init_done_o rises in the cycle the state becomes IDLE.
- flush_i:
  - In IDLE: go to SWEEP with sweep_idx=0; init_done_o falls the next cycle.
  - In SWEEP: restarts the sweep at 0.
  - flush_i takes priority over a same-cycle update, which is dropped.
  - A same-cycle lookup still returns the pre-flush contents.
- Lookup, 1-cycle latency:
  - If lookup_valid_i is high in cycle N and the state is IDLE: pred_valid_o=1 in cycle N+1, and pred_taken_o = entry.valid & entry.ctr[1].
  - In SWEEP, or when no lookup was made: pred_valid_o=0 and pred_taken_o=0.
  - The outputs are registered and hold for exactly one cycle.
- Update, IDLE only; ignored in SWEEP:
  - Invalid entry: valid := 1, ctr := taken ? 2'b10 : 2'b01.
  - Valid entry: saturating count, up on taken (max 2'b11) and down on not-taken (min 2'b00); no wrap-around.
  - Written at the clock edge ending the update cycle.
- Lookup and update in the same cycle to the same index: the lookup reads the pre-update value (read-before-write) unless the optional feature is enabled.
- Different indices: both operations proceed independently, with no stall.
- No backpressure; every request issued in IDLE is accepted.

Optional Feature:
- Macro: BHT_WRITE_BYPASS_EN.
- Defined: when a lookup and an update hit the same index in the same IDLE cycle, the prediction reflects the post-update entry.
  - Example: an invalid entry with a taken update returns pred_taken_o=1.
- Not defined: read-before-write, as specified above.
- Either way, the storage contents after the cycle are identical.

Test Plan:
- Pulse rst_i for 1 cycle, then idle -> init_done_o=0 for exactly 128 cycles and 1 from cycle 128. A lookup issued during the sweep gives pred_valid_o=0.
- After init, lookup pc=0x8000_0010 -> next cycle pred_valid_o=1, pred_taken_o=0. Updates taken x3 to the same PC give ctr 10, 11, 11 (saturates); a lookup then gives taken=1. Two not-taken updates give ctr 01 and then taken=0.
- Updates to pc=0x8000_0004 and pc=0x8000_0104 (same index, 128 entries, offset 1) alias: a taken update via the first makes a lookup of the second predict taken=1.
- Same-cycle lookup and taken update to a fresh index -> pred_taken_o=0 without BHT_WRITE_BYPASS_EN, =1 with it. A following lookup gives 1 in both builds.
- Train index 5 to ctr 11, pulse flush_i, then pulse flush_i again at sweep cycle 60 -> init_done_o returns 128 cycles after the second flush. A lookup of index 5 then gives taken=0. An update issued during the sweep is dropped.
- Assert rst_i at sweep cycle 100 -> the sweep restarts and init_done_o rises 128 cycles after rst_i deasserts.
